spi_cmd_controller: RTL and testbench
=====================================

// Module: spi_cmd_controller
// PURPOSE
//  Command sequencer behind spi_serdes. Decodes each received 40-bit packet into one
//  register-bus read or write, runs the bus handshake, and loads a 40-bit response into
//  the serdes output register. The master shifts that response out during the next packet.
//  Sits between spi_serdes (rx/tx side) and the mixer control-register bus.
// PARAMETERS
//  PACKET_WIDTH    40   serdes packet width; fixed layout below, must be 40
//  ADDR_WIDTH      6    register address width (64 words)
//  DATA_WIDTH      32   register data width
//  TIMEOUT_CYCLES  255  max clk cycles waiting for bus_ack (only with SPI_CTRL_TIMEOUT_EN)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous, active-high reset
//  rx_data    in   40  packet from serdes inputReg
//  rx_valid   in   1   serdes dataReady; 1-cycle pulse per packet
//  tx_data    out  40  response to serdes toOutput
//  tx_load    out  1   serdes loadOutput; 1-cycle pulse
//  bus_addr   out  6   register address
//  bus_wdata  out  32  write data
//  bus_wr     out  1   write request, held until ack
//  bus_rd     out  1   read request, held until ack
//  bus_rdata  in   32  read data, valid with bus_ack
//  bus_ack    in   1   request complete
//  busy       out  1   high whenever state != IDLE
// BEHAVIOUR
//  Packet: [39]=rnw (1=read), [38]=inc, [37:32]=addr, [31:0]=wdata (ignored on read).
//  Address: inc=0 -> use addr, then ptr<=addr+1. inc=1 -> use ptr, then ptr<=ptr+1.
//    ptr is 6 bits, wraps 6'h3F->6'h00. ptr resets to 0.
//  FSM: IDLE, WAIT, LOAD.
//   IDLE: rx_valid -> latch packet, resolve address, drive bus_addr/bus_wdata,
//     assert bus_rd or bus_wr (registered, high next cycle) -> WAIT.
//   WAIT: bus_ack=1 -> drop request the next cycle, capture bus_rdata (reads) -> LOAD.
//   LOAD: tx_load=1 for exactly one cycle with tx_data valid -> IDLE.
//  Bus rules: addr/wdata stable while request high. Exactly one of bus_rd/bus_wr high.
//    bus_ack is sampled only while a request is high.
//  Latency: rx_valid at cycle N -> request high N+1. Ack at cycle M -> tx_load at M+1.
//    Zero-wait bus gives tx_load at N+2.
//  Response: tx_data = {timeout, overrun, used_addr[5:0], data}.
//    data = rdata for reads, echoed wdata for writes, 32'h0 on timeout.
//  Overrun: rx_valid while busy -> packet dropped, sticky overrun flag set.
//    Flag is reported and cleared on the next tx_load.
//    If set and clear coincide, set wins (flag stays 1).
//  rx_valid on the same cycle as the LOAD->IDLE transition counts as overrun.
//  Reset (any time, incl. mid-handshake): state=IDLE; bus_rd=bus_wr=0; tx_load=0;
//    tx_data=0; bus_addr=0; bus_wdata=0; ptr=0; overrun=0; busy=0.
//    The bus slave must tolerate an abandoned request.
// CONFIGURATION
//  SPI_CTRL_TIMEOUT_EN defined:
//    - counter (width $clog2(TIMEOUT_CYCLES+1)) clears on WAIT entry.
//    - WAIT exits after TIMEOUT_CYCLES cycles without ack: request dropped, timeout bit=1,
//      data=0, -> LOAD.
//    - ack on the final counted cycle counts as success.
//  Not defined: no counter; WAIT holds until bus_ack; timeout bit is always 0.
// TESTING
//  1 rx 0x05_12345678 (write addr 5), ack after 3 cycles -> bus_wr with addr 5,
//    wdata 0x12345678 held 3 cycles; tx_data 0x05_12345678, tx_load 1 cycle later.
//  2 rx 0x8A_xxxxxxxx, bus_rdata 0xCAFEF00D, zero-wait ack -> bus_rd addr 0x0A;
//    tx_data 0x0A_CAFEF00D; tx_load at N+2.
//  3 rx 0xBF (read 0x3F), then three reads 0xC0 (inc) -> addresses 0x3F,0x00,0x01,0x02.
//  4 second rx_valid during WAIT -> dropped; next response bit38=1; following response bit38=0.
//  5 TIMEOUT_EN, TIMEOUT_CYCLES=8, ack never -> bus_rd drops after 8 cycles;
//    tx_data {1,0,addr,32'h0}. Without the macro: busy stays high indefinitely.
//  6 rst pulse mid-WAIT -> all outputs 0 asynchronously; a fresh packet then completes normally.

Source files
------------

// File: rtl/spi_cmd_controller.sv
// Command sequencer behind spi_serdes: decodes 40-bit packets into register-bus reads/writes
// and returns a 40-bit response. Optional bus_ack timeout: define SPI_CTRL_TIMEOUT_EN.
module spi_cmd_controller #(
  parameter int PACKET_WIDTH   = 40,
  parameter int ADDR_WIDTH     = 6,
`ifdef SPI_CTRL_TIMEOUT_EN
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
`else
  parameter int DATA_WIDTH     = 32
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PACKET_WIDTH-1:0] rx_data,
  input  logic                    rx_valid,
  output logic [PACKET_WIDTH-1:0] tx_data,
  output logic                    tx_load,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wdata,
  output logic                    bus_wr,
  output logic                    bus_rd,
  input  logic [DATA_WIDTH-1:0]   bus_rdata,
  input  logic                    bus_ack,
  output logic                    busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_LOAD
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [ADDR_WIDTH-1:0]   used_addr;
  logic [DATA_WIDTH-1:0]   resp_data;
  logic                    overrun;
  logic                    start;
  logic                    done;
  logic                    timed_out;

  // Packet fields: [39]=rnw, [38]=inc, [37:32]=addr, [31:0]=wdata.
  wire                  pkt_rnw  = rx_data[PACKET_WIDTH-1];
  wire                  pkt_inc  = rx_data[PACKET_WIDTH-2];
  wire [ADDR_WIDTH-1:0] pkt_addr = rx_data[DATA_WIDTH +: ADDR_WIDTH];

  assign used_addr = pkt_inc ? ptr : pkt_addr;
  assign busy      = (state != S_IDLE);

`ifdef SPI_CTRL_TIMEOUT_EN
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  logic [CNT_WIDTH-1:0] tmo_cnt;
`endif

  // NOTE: every signal gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    done       = 1'b0;
    timed_out  = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_valid) begin
          start      = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus_ack) begin
          done       = 1'b1;
          state_next = S_LOAD;
        end
`ifdef SPI_CTRL_TIMEOUT_EN
        else if (tmo_cnt == CNT_LAST) begin
          done       = 1'b1;
          timed_out  = 1'b1;
          state_next = S_LOAD;
        end
`endif
      end
      S_LOAD:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Reads return the bus data, writes echo what was written, timeouts return zero.
  assign resp_data = timed_out ? '0 : (bus_rd ? bus_rdata : bus_wdata);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_rd    <= 1'b0;
      bus_wr    <= 1'b0;
      tx_data   <= '0;
      tx_load   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state   <= state_next;
      tx_load <= done;

      if (start) begin
        bus_addr  <= used_addr;
        bus_wdata <= rx_data[DATA_WIDTH-1:0];
        bus_rd    <= pkt_rnw;
        bus_wr    <= ~pkt_rnw;
        ptr       <= used_addr + 1'b1;
      end

      if (done) begin
        bus_rd  <= 1'b0;
        bus_wr  <= 1'b0;
        // A packet dropped on the ack cycle itself is still reported in this response.
        tx_data <= {timed_out, overrun | rx_valid, bus_addr, resp_data};
      end

      // Set wins over the clear that happens on the tx_load cycle.
      if (rx_valid && busy) begin
        overrun <= 1'b1;
      end else if (tx_load) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef SPI_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (start) begin
      tmo_cnt <= '0;
    end else if (state == S_WAIT) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_cmd_controller.sv
// Self-checking bench for spi_cmd_controller: directed scenarios plus randomized
// transactions compared against a transaction-level model of address pointer and overrun.
`timescale 1ns/1ps
module tb_spi_cmd_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] rx_data;
  logic        rx_valid;
  logic [39:0] tx_data;
  logic        tx_load;
  logic [5:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_wr;
  logic        bus_rd;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Reference model state: next auto-increment address and a pending overrun report.
  int ptr_m  = 0;
  bit pend_m = 1'b0;

`ifdef SPI_CTRL_TIMEOUT_EN
  localparam int TMO = 255;
`endif

  spi_cmd_controller dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_load   (tx_load),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_wr    (bus_wr),
    .bus_rd    (bus_rd),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One packet through the full handshake. drop: 0 none, 1 extra rx_valid on the first
  // wait cycle, 2 on the ack cycle, 3 on the tx_load cycle.
  task automatic do_txn(input bit rnw, input bit inc, input logic [5:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int delay, input int drop, input string name);
    logic [5:0]  used;
    logic [39:0] exp;
    bit          ov;
    used   = inc ? ptr_m[5:0] : addr;
    ptr_m  = (int'(used) + 1) % 64;
    ov     = pend_m;
    pend_m = 1'b0;
    @(negedge clk);
    rx_data  = {rnw, inc, addr, wdata};
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = {$urandom, $urandom} ;
    for (int i = 0; i <= delay; i++) begin
      total++;
      if (bus_rd !== rnw || bus_wr !== !rnw || bus_addr !== used || busy !== 1'b1 ||
          (!rnw && bus_wdata !== wdata) || tx_load !== 1'b0) begin
        bad++;
        $display("FAIL %s request cycle %0d: rd=%b wr=%b addr=%h wdata=%h busy=%b load=%b, want rd=%b wr=%b addr=%h wdata=%h busy=1 load=0",
                 name, i, bus_rd, bus_wr, bus_addr, bus_wdata, busy, tx_load, rnw, !rnw, used, wdata);
      end
      bus_ack   = (i == delay);
      bus_rdata = (i == delay) ? rdata : $urandom;
      if ((drop == 1 && i == 0) || (drop == 2 && i == delay)) begin
        rx_valid = 1'b1;
        ov       = 1'b1;
      end
      @(negedge clk);
      bus_ack   = 1'b0;
      rx_valid  = 1'b0;
      bus_rdata = $urandom;
    end
    exp = {1'b0, ov, used, rnw ? rdata : wdata};
    total++;
    if (tx_load !== 1'b1 || tx_data !== exp || bus_rd !== 1'b0 || bus_wr !== 1'b0) begin
      bad++;
      $display("FAIL %s response: load=%b data=%h rd=%b wr=%b, want load=1 data=%h rd=0 wr=0",
               name, tx_load, tx_data, bus_rd, bus_wr, exp);
    end
    if (drop == 3) begin
      rx_valid = 1'b1;
      pend_m   = 1'b1;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    total++;
    if (tx_load !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s idle after load: load=%b busy=%b, want 0 0", name, tx_load, busy);
    end
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    rx_data   = '0;
    rx_valid  = 1'b0;
    bus_rdata = '0;
    bus_ack   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({tx_data, tx_load, bus_addr, bus_wdata, bus_wr, bus_rd, busy} !== 82'h0) begin
      bad++;
      $display("FAIL reset state: tx=%h load=%b addr=%h wdata=%h wr=%b rd=%b busy=%b, want all 0",
               tx_data, tx_load, bus_addr, bus_wdata, bus_wr, bus_rd, busy);
    end
    ptr_m  = 0;
    pend_m = 1'b0;
  endtask

  task automatic test_write;
    do_txn(1'b0, 1'b0, 6'h05, 32'h12345678, 32'hDEADBEEF, 2, 0, "write_addr5");
  endtask

  task automatic test_read_zero_wait;
    do_txn(1'b1, 1'b0, 6'h0A, 32'h0BAD0BAD, 32'hCAFEF00D, 0, 0, "read_zero_wait");
  endtask

  task automatic test_auto_inc;
    do_txn(1'b1, 1'b0, 6'h3F, $urandom, $urandom, 1, 0, "inc_base_3f");
    for (int k = 0; k < 3; k++)
      do_txn(1'b1, 1'b1, 6'h00, $urandom, $urandom, k, 0, "inc_wrap");
  endtask

  task automatic test_overrun;
    do_txn(1'b0, 1'b0, 6'h11, $urandom, $urandom, 2, 1, "ovr_in_wait");
    do_txn(1'b1, 1'b0, 6'h12, $urandom, $urandom, 1, 0, "ovr_cleared");
    do_txn(1'b1, 1'b1, 6'h00, $urandom, $urandom, 0, 3, "ovr_in_load");
    do_txn(1'b0, 1'b1, 6'h00, $urandom, $urandom, 1, 0, "ovr_after_load");
    do_txn(1'b0, 1'b0, 6'h20, $urandom, $urandom, 2, 2, "ovr_on_ack");
    do_txn(1'b1, 1'b0, 6'h21, $urandom, $urandom, 0, 0, "ovr_cleared2");
  endtask

  task automatic test_random;
    for (int k = 0; k < 40; k++) begin
      int d;
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      do_txn(1'($urandom), 1'($urandom), 6'($urandom), $urandom, $urandom,
             int'($urandom_range(0, 4)), d, "random");
    end
  endtask

  task automatic test_stall;
    logic [5:0]  used;
    logic [39:0] exp;
    bit          ok;
    bit          ov;
    used   = 6'h2C;
    ptr_m  = 45;
    ov     = pend_m;
    pend_m = 1'b0;
    ok     = 1'b1;
    @(negedge clk);
    rx_data  = {1'b1, 1'b0, used, 32'h55AA55AA};
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
`ifdef SPI_CTRL_TIMEOUT_EN
    for (int i = 0; i < TMO; i++) begin
      if (bus_rd !== 1'b1 || busy !== 1'b1 || tx_load !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL timeout_hold: request not held for %0d cycles", TMO);
    end
    exp = {1'b1, ov, used, 32'h0};
`else
    for (int i = 0; i < 300; i++) begin
      if (bus_rd !== 1'b1 || busy !== 1'b1 || tx_load !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL stall_hold: request/busy dropped without ack, want held 300 cycles");
    end
    bus_ack   = 1'b1;
    bus_rdata = 32'h13572468;
    @(negedge clk);
    bus_ack = 1'b0;
    exp = {1'b0, ov, used, 32'h13572468};
`endif
    total++;
    if (tx_load !== 1'b1 || tx_data !== exp || bus_rd !== 1'b0) begin
      bad++;
      $display("FAIL stall_response: load=%b data=%h rd=%b, want load=1 data=%h rd=0",
               tx_load, tx_data, bus_rd, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    rx_data  = {1'b0, 1'b0, 6'h33, 32'hA5A5A5A5};
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({tx_data, tx_load, bus_addr, bus_wdata, bus_wr, bus_rd, busy} !== 82'h0) begin
      bad++;
      $display("FAIL async_reset_mid_wait: tx=%h load=%b addr=%h wdata=%h wr=%b rd=%b busy=%b, want all 0",
               tx_data, tx_load, bus_addr, bus_wdata, bus_wr, bus_rd, busy);
    end
    @(negedge clk);
    rst    = 1'b0;
    ptr_m  = 0;
    pend_m = 1'b0;
    do_txn(1'b0, 1'b1, 6'h15, $urandom, $urandom, 1, 0, "after_reset_inc");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_zero_wait();
    test_auto_inc();
    test_overrun();
    test_random();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
